// File: rtl/pipe_arbiter_if.sv
// pipe_arbiter_if -- request/response bus of the pipelined round-robin arbiter.
//   master modport : requester/consumer side (drives enable, mask, requests).
//   slave  modport : arbiter side (drives grant, response, status).
//   io_en          : arbiter enable (0 blocks new grants, pipe still drains)
//   io_mask[3:0]   : per-requester enable
//   io_req_valid   : per-requester request, io_req_bits 8 bits per requester
//   io_req_ready   : one-hot grant (combinational)
//   io_resp_*      : one-hot response valid, payload and owning tag
//   io_busy        : either pipe stage occupied
//   io_issue_count : grants since reset, wrapping
interface pipe_arbiter_if;
  logic        io_en;
  logic [3:0]  io_mask;
  logic [3:0]  io_req_valid;
  logic [31:0] io_req_bits;
  logic [3:0]  io_req_ready;
  logic [3:0]  io_resp_valid;
  logic [7:0]  io_resp_bits;
  logic [1:0]  io_resp_tag;
  logic        io_busy;
  logic [7:0]  io_issue_count;

  modport master (
    output io_en, io_mask, io_req_valid, io_req_bits,
    input  io_req_ready, io_resp_valid, io_resp_bits, io_resp_tag,
           io_busy, io_issue_count
  );

  modport slave (
    input  io_en, io_mask, io_req_valid, io_req_bits,
    output io_req_ready, io_resp_valid, io_resp_bits, io_resp_tag,
           io_busy, io_issue_count
  );
endinterface

// File: rtl/pipe_arbiter.sv
// pipe_arbiter -- 4-way round-robin arbiter feeding a fixed 2-stage pipe.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : pipe_arbiter_if.slave (requests in, grant/response/status out)
// A grant in cycle N appears as a one-hot response in cycle N+2.
module pipe_arbiter (
  input  logic           clk,
  input  logic           reset,
  pipe_arbiter_if.slave  bus
);

  logic [3:0] w_elig;
  logic [3:0] w_grant;
  logic [1:0] w_gnt_idx;
  logic [1:0] w_idx;
  logic       w_any;
  logic [7:0] w_gnt_data;

  logic [1:0] r_rr_ptr;
  logic       r_s1_v;
  logic [7:0] r_s1_data;
  logic [1:0] r_s1_tag;
  logic       r_s2_v;
  logic [7:0] r_s2_data;
  logic [1:0] r_s2_tag;
  logic [7:0] r_issue_cnt;

  // Reset gating keeps the combinational grant at zero while reset is held.
  assign w_elig = bus.io_req_valid & bus.io_mask & {4{bus.io_en & reset}};

  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_any     = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_idx = r_rr_ptr + k[1:0];
      if (!w_any && w_elig[w_idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (w_any) w_grant = 4'(4'b0001 << w_gnt_idx);
  end

  assign w_gnt_data = bus.io_req_bits[{w_gnt_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr    <= '0;
      r_s1_v      <= 1'b0;
      r_s1_data   <= '0;
      r_s1_tag    <= '0;
      r_s2_v      <= 1'b0;
      r_s2_data   <= '0;
      r_s2_tag    <= '0;
      r_issue_cnt <= '0;
    end else begin
      r_s1_v <= w_any;
      if (w_any) begin
        r_rr_ptr    <= w_gnt_idx + 2'd1;
        r_s1_data   <= w_gnt_data;
        r_s1_tag    <= w_gnt_idx;
        r_issue_cnt <= r_issue_cnt + 8'd1;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_data <= r_s1_data;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign bus.io_req_ready   = w_grant;
  assign bus.io_resp_valid  = r_s2_v ? 4'(4'b0001 << r_s2_tag) : '0;
  assign bus.io_resp_bits   = r_s2_data;
  assign bus.io_resp_tag    = r_s2_tag;
  assign bus.io_busy        = r_s1_v | r_s2_v;
  assign bus.io_issue_count = r_issue_cnt;

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb_pipe_arbiter -- randomized and directed bench for pipe_arbiter, checked
// against a transaction-level model: a round-robin pick function plus a list
// of in-flight responses aged once per clock.
module tb_pipe_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pipe_arbiter_if bus ();

  pipe_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         age;
    logic [1:0] tag;
    logic [7:0] data;
  } flight_t;

  flight_t    m_q[$];
  int         m_rr;
  int         m_cnt;
  logic [1:0] m_last_tag;
  logic [7:0] m_last_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [3:0] elig, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (elig[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_rr        = 0;
    m_cnt       = 0;
    m_last_tag  = '0;
    m_last_data = '0;
  endtask

  // Checks every output mid-cycle, then advances the model across the next edge.
  task automatic step();
    logic [3:0] elig;
    logic [3:0] exp_rv;
    logic       exp_busy;
    int         g;
    flight_t    q2[$];
    @(negedge clk);
    elig = bus.io_req_valid & bus.io_mask & {4{bus.io_en}};
    if (!reset) elig = '0;
    g = model_pick(elig, m_rr);
    exp_rv   = '0;
    exp_busy = 1'b0;
    foreach (m_q[i]) begin
      exp_busy = 1'b1;
      if (m_q[i].age == 2) exp_rv = 4'(4'b0001 << m_q[i].tag);
    end
    check("req_ready",   32'(bus.io_req_ready),   (g >= 0) ? 32'(1 << g) : 32'd0);
    check("resp_valid",  32'(bus.io_resp_valid),  32'(exp_rv));
    check("resp_bits",   32'(bus.io_resp_bits),   32'(m_last_data));
    check("resp_tag",    32'(bus.io_resp_tag),    32'(m_last_tag));
    check("busy",        32'(bus.io_busy),        32'(exp_busy));
    check("issue_count", 32'(bus.io_issue_count), 32'(m_cnt));
    @(posedge clk);
    if (reset) begin
      foreach (m_q[i]) begin
        m_q[i].age++;
        if (m_q[i].age == 2) begin
          m_last_tag  = m_q[i].tag;
          m_last_data = m_q[i].data;
        end
        if (m_q[i].age <= 2) q2.push_back(m_q[i]);
      end
      m_q = q2;
      if (g >= 0) begin
        m_q.push_back('{age: 1, tag: 2'(g), data: bus.io_req_bits[8*g +: 8]});
        m_rr  = (g + 1) % 4;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] mask,
                       input logic [3:0] valid, input logic [31:0] bits);
    bus.io_en        = en;
    bus.io_mask      = mask;
    bus.io_req_valid = valid;
    bus.io_req_bits  = bits;
  endtask

  // Asserts reset mid-cycle and checks that outputs clear without a clock edge.
  task automatic mid_reset();
    reset = 1'b0;
    #2;
    check("rst_req_ready",  32'(bus.io_req_ready),   32'd0);
    check("rst_resp_valid", 32'(bus.io_resp_valid),  32'd0);
    check("rst_resp_bits",  32'(bus.io_resp_bits),   32'd0);
    check("rst_resp_tag",   32'(bus.io_resp_tag),    32'd0);
    check("rst_busy",       32'(bus.io_busy),        32'd0);
    check("rst_count",      32'(bus.io_issue_count), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_clear();
    reset = 1'b0;
    drive(1'b1, 4'b1111, 4'b1111, 32'h44332211);
    repeat (2) @(posedge clk);
    #1;
    mid_reset();

    // single request with payload A5
    drive(1'b1, 4'b1111, 4'b0001, 32'h000000A5);
    step();
    drive(1'b1, 4'b1111, 4'b0000, 32'h0);
    repeat (3) step();

    // all four requesting continuously for five grants
    drive(1'b1, 4'b1111, 4'b1111, 32'hD4C3B2A1);
    repeat (5) step();
    drive(1'b1, 4'b1111, 4'b0000, 32'h0);
    repeat (3) step();

    // requester 2 masked out
    drive(1'b1, 4'b1011, 4'b1111, 32'h88776655);
    repeat (6) step();

    // enable dropped the cycle after a grant; pipe drains
    drive(1'b1, 4'b1111, 4'b0100, 32'h00990000);
    step();
    drive(1'b0, 4'b1111, 4'b1111, 32'h12345678);
    repeat (4) step();

    // reset with both stages full, then first grant from index 0
    drive(1'b1, 4'b1111, 4'b1111, 32'hCAFEBEEF);
    repeat (3) step();
    mid_reset();
    drive(1'b1, 4'b1111, 4'b1010, 32'h11223344);
    repeat (4) step();

    // 256 grants from reset wrap the counter
    mid_reset();
    drive(1'b1, 4'b1111, 4'b1111, 32'h01020304);
    repeat (256) step();
    drive(1'b1, 4'b1111, 4'b0000, 32'h0);
    step();
    check("count_wrap", 32'(bus.io_issue_count), 32'd0);

    // randomized traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), $urandom);
      if ($urandom_range(0, 99) == 0) mid_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
